// File: rtl/zeroriscy_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : zeroriscy_mem_arbiter
//  Purpose  : Two-requester req/gnt/rvalid arbiter onto one SRAM slave port,
//             with in-order response routing and m0 starvation guard.
//  Revision : 1.0
// ============================================================================
module zeroriscy_mem_arbiter #(
  parameter int MAX_OUTST    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic        m0_err,
  output logic [31:0] m0_rdata,

  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic        m1_err,
  output logic [31:0] m1_rdata,

  output logic        s_req,
  output logic        s_we,
  output logic [3:0]  s_be,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_gnt,
  input  logic        s_rvalid,
  input  logic        s_err,
  input  logic [31:0] s_rdata,

  output logic        protocol_err
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [CNT_W-1:0] C_MAX_CNT    = CNT_W'(MAX_OUTST);
  localparam logic [PTR_W-1:0] C_LAST_PTR   = PTR_W'(MAX_OUTST - 1);
  localparam logic [STV_W-1:0] C_STARVE_MAX = STV_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]     count;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [MAX_OUTST-1:0] id_fifo;
  logic [STV_W-1:0]     starve;

  logic full;
  logic m0_wins;
  logic m1_wins;
  logic accept;
  logic pop;
  logic head_id;

  // Full comes only from registered count, so a pop never frees a slot early.
  assign full    = (count == C_MAX_CNT);
  assign s_req   = (m0_req | m1_req) & ~full;

  assign m0_wins = m0_req & (~m1_req | (starve == C_STARVE_MAX));
  assign m1_wins = m1_req & ~m0_wins;

  assign s_we    = m1_wins ? m1_we    : m0_we;
  assign s_be    = m1_wins ? m1_be    : m0_be;
  assign s_addr  = m1_wins ? m1_addr  : m0_addr;
  assign s_wdata = m1_wins ? m1_wdata : m0_wdata;

  assign accept  = s_req & s_gnt;
  assign m0_gnt  = accept & m0_wins;
  assign m1_gnt  = accept & m1_wins;

  assign pop       = s_rvalid & (count != '0);
  assign head_id   = id_fifo[rd_ptr];
  assign m0_rvalid = pop & ~head_id;
  assign m1_rvalid = pop &  head_id;

  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;
  assign m0_err   = s_err;
  assign m1_err   = s_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      id_fifo <= '0;
    end else begin
      if (accept) begin
        id_fifo[wr_ptr] <= m1_wins;
        wr_ptr          <= (wr_ptr == C_LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == C_LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Counting is frozen on cycles where no arbitration could complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve <= '0;
    end else if (!m0_req || m0_gnt) begin
      starve <= '0;
    end else if (s_gnt && !full && (starve != C_STARVE_MAX)) begin
      starve <= starve + STV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      protocol_err <= 1'b0;
    end else if (s_rvalid && (count == '0)) begin
      protocol_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire
